// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: sole owner of the shared SRAM macro port.
// Arbitrates three requesters (ADC sample write, EPC write, word read) and
// sequences each grant through precharge, access and completion phases.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   adc_req/bank/addr/wdata/done     sensor write requester
//   epc_req/addr/wdata/done          EPC write requester (bank 3'd1 fixed)
//   rd_req/bank/addr/data/valid      read requester
//   bank_err                         grant aborted, bank not one-hot
//   busy                             high whenever the sequencer is not idle
//   mem_read_in, mem_data_out, PC_B, WE, SE, mem_address, mem_sel  macro port
module mem_access_arbiter #(
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned PRECHARGE_CYC = 1,
  parameter int unsigned ACCESS_CYC    = 1,
  parameter int unsigned STARVE_MAX    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_req,
  input  logic [2:0]        adc_bank,
  input  logic [ADDR_W-1:0] adc_addr,
  input  logic [DATA_W-1:0] adc_wdata,
  output logic              adc_done,
  input  logic              epc_req,
  input  logic [ADDR_W-1:0] epc_addr,
  input  logic [DATA_W-1:0] epc_wdata,
  output logic              epc_done,
  input  logic              rd_req,
  input  logic [2:0]        rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              bank_err,
  output logic              busy,
  input  logic [DATA_W-1:0] mem_read_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              PC_B,
  output logic              WE,
  output logic              SE,
  output logic [ADDR_W-1:0] mem_address,
  output logic [2:0]        mem_sel
);

  localparam int unsigned MaxCyc  = (PRECHARGE_CYC > ACCESS_CYC) ? PRECHARGE_CYC : ACCESS_CYC;
  localparam int unsigned CntW    = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0]    PrechLast = CntW'(PRECHARGE_CYC - 1);
  localparam logic [CntW-1:0]    AccLast   = CntW'(ACCESS_CYC - 1);
  localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StPrech, StAccess, StDone} state_e;
  typedef enum logic [1:0] {OpAdc, OpEpc, OpRead} op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d, grant_op;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, grant_addr;
  logic [2:0]          sel_q, sel_d, grant_bank;
  logic [DATA_W-1:0]   wdata_q, wdata_d, grant_wdata;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                grant, bank_ok;
  logic                pc_b_q, we_q, se_q, busy_q;
  logic                adc_done_q, epc_done_q, rd_valid_q, bank_err_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    grant       = 1'b0;
    grant_op    = OpAdc;
    grant_addr  = adc_addr;
    grant_bank  = adc_bank;
    grant_wdata = adc_wdata;

    unique case (state_q)
      StIdle: begin
        // A starved read overrides the fixed write priority.
        if (rd_req && (starve_q == StarveTop)) begin
          grant      = 1'b1;
          grant_op   = OpRead;
          grant_addr = rd_addr;
          grant_bank = rd_bank;
        end else if (adc_req) begin
          grant      = 1'b1;
        end else if (epc_req) begin
          grant       = 1'b1;
          grant_op    = OpEpc;
          grant_addr  = epc_addr;
          grant_bank  = 3'd1;
          grant_wdata = epc_wdata;
        end else if (rd_req) begin
          grant      = 1'b1;
          grant_op   = OpRead;
          grant_addr = rd_addr;
          grant_bank = rd_bank;
        end

        if (!rd_req || (grant && (grant_op == OpRead))) begin
          starve_d = '0;
        end else if (grant && (starve_q != StarveTop)) begin
          starve_d = starve_q + 1'b1;
        end

        if (grant) begin
          op_d  = grant_op;
          err_d = !bank_ok;
          cnt_d = '0;
          if (bank_ok) begin
            state_d = StPrech;
            addr_d  = grant_addr;
            sel_d   = grant_bank;
            if (grant_op != OpRead) wdata_d = grant_wdata;
          end else begin
            // Bad bank: skip straight to completion, macro port untouched.
            state_d = StDone;
          end
        end
      end
      StPrech: begin
        if (cnt_q == PrechLast) begin
          state_d = StAccess;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAccess: begin
        if (cnt_q == AccLast) begin
          state_d = StDone;
          if (op_q == OpRead) rdata_d = mem_read_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bank_ok = (grant_bank != 3'd0) && ((grant_bank & (grant_bank - 3'd1)) == 3'd0);

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= OpAdc;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      pc_b_q     <= 1'b1;
      we_q       <= 1'b0;
      se_q       <= 1'b0;
      busy_q     <= 1'b0;
      adc_done_q <= 1'b0;
      epc_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      bank_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      pc_b_q     <= (state_d != StPrech);
      we_q       <= (state_d == StAccess) && (op_d != OpRead);
      se_q       <= (state_d == StAccess) && (op_d == OpRead);
      busy_q     <= (state_d != StIdle);
      adc_done_q <= (state_d == StDone) && (op_d == OpAdc) && !err_d;
      epc_done_q <= (state_d == StDone) && (op_d == OpEpc) && !err_d;
      rd_valid_q <= (state_d == StDone) && (op_d == OpRead) && !err_d;
      bank_err_q <= (state_d == StDone) && err_d;
    end
  end

  assign mem_address  = addr_q;
  assign mem_sel      = sel_q;
  assign mem_data_out = wdata_q;
  assign rd_data      = rdata_q;
  assign PC_B         = pc_b_q;
  assign WE           = we_q;
  assign SE           = se_q;
  assign busy         = busy_q;
  assign adc_done     = adc_done_q;
  assign epc_done     = epc_done_q;
  assign rd_valid     = rd_valid_q;
  assign bank_err     = bank_err_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios with literal expectations,
// then randomized requests checked every cycle against a transaction-timeline model.
module tb_mem_access_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int PRE = 1;
  localparam int ACC = 1;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          adc_req = 1'b0, epc_req = 1'b0, rd_req = 1'b0;
  logic [2:0]    adc_bank = '0, rd_bank = '0;
  logic [AW-1:0] adc_addr = '0, epc_addr = '0, rd_addr = '0;
  logic [DW-1:0] adc_wdata = '0, epc_wdata = '0, mem_read_in = '0;
  logic          adc_done, epc_done, rd_valid, bank_err, busy, PC_B, WE, SE;
  logic [DW-1:0] rd_data, mem_data_out;
  logic [AW-1:0] mem_address;
  logic [2:0]    mem_sel;

  mem_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .PRECHARGE_CYC(PRE), .ACCESS_CYC(ACC), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .adc_req(adc_req), .adc_bank(adc_bank), .adc_addr(adc_addr), .adc_wdata(adc_wdata),
    .adc_done(adc_done),
    .epc_req(epc_req), .epc_addr(epc_addr), .epc_wdata(epc_wdata), .epc_done(epc_done),
    .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .bank_err(bank_err), .busy(busy),
    .mem_read_in(mem_read_in), .mem_data_out(mem_data_out),
    .PC_B(PC_B), .WE(WE), .SE(SE), .mem_address(mem_address), .mem_sel(mem_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a granted transaction occupies cycles 1..len after its grant edge;
  // precharge in 1..PRE, access in PRE+1..PRE+ACC, completion at PRE+ACC+1.
  // A bad-bank grant is a single completion cycle with bank_err.
  bit            m_active = 1'b0;
  bit            m_err = 1'b0;
  int            m_off = 0;
  int            m_kind = 0;   // 0 adc, 1 epc, 2 read
  int            m_starve = 0;
  int            g_kind;
  logic [2:0]    g_bank;
  logic [AW-1:0] e_addr = '0;
  logic [2:0]    e_sel = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_active = 1'b0; m_err = 1'b0; m_off = 0; m_kind = 0; m_starve = 0;
        e_addr = '0; e_sel = '0; e_wdata = '0; e_rdata = '0;
      end else if (m_active) begin
        if (m_off == (m_err ? 1 : PRE + ACC + 1)) begin
          m_active = 1'b0;
        end else begin
          if (!m_err && m_kind == 2 && m_off == PRE + ACC) e_rdata = mem_read_in;
          m_off++;
        end
      end else begin
        g_kind = -1;
        if (rd_req && m_starve == SMAX) g_kind = 2;
        else if (adc_req) g_kind = 0;
        else if (epc_req) g_kind = 1;
        else if (rd_req) g_kind = 2;
        if (!rd_req || g_kind == 2) m_starve = 0;
        else if (g_kind >= 0 && m_starve < SMAX) m_starve++;
        if (g_kind >= 0) begin
          g_bank = (g_kind == 0) ? adc_bank : (g_kind == 1) ? 3'd1 : rd_bank;
          m_kind = g_kind;
          m_err = ($countones(g_bank) != 1);
          m_active = 1'b1;
          m_off = 1;
          if (!m_err) begin
            e_addr = (g_kind == 0) ? adc_addr : (g_kind == 1) ? epc_addr : rd_addr;
            e_sel = g_bank;
            if (g_kind == 0) e_wdata = adc_wdata;
            if (g_kind == 1) e_wdata = epc_wdata;
          end
        end
      end
    end
  end

  logic x_pcb, x_we, x_se, x_busy, x_adc, x_epc, x_rdv, x_berr, run;
  always_comb begin
    run    = m_active && !m_err;
    x_pcb  = !(run && m_off >= 1 && m_off <= PRE);
    x_we   = run && m_kind != 2 && m_off > PRE && m_off <= PRE + ACC;
    x_se   = run && m_kind == 2 && m_off > PRE && m_off <= PRE + ACC;
    x_busy = m_active;
    x_adc  = run && m_kind == 0 && m_off == PRE + ACC + 1;
    x_epc  = run && m_kind == 1 && m_off == PRE + ACC + 1;
    x_rdv  = run && m_kind == 2 && m_off == PRE + ACC + 1;
    x_berr = m_active && m_err && m_off == 1;
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("PC_B", 32'(PC_B), 32'(x_pcb));
        chk("WE", 32'(WE), 32'(x_we));
        chk("SE", 32'(SE), 32'(x_se));
        chk("busy", 32'(busy), 32'(x_busy));
        chk("adc_done", 32'(adc_done), 32'(x_adc));
        chk("epc_done", 32'(epc_done), 32'(x_epc));
        chk("rd_valid", 32'(rd_valid), 32'(x_rdv));
        chk("bank_err", 32'(bank_err), 32'(x_berr));
        chk("mem_address", 32'(mem_address), 32'(e_addr));
        chk("mem_sel", 32'(mem_sel), 32'(e_sel));
        chk("mem_data_out", 32'(mem_data_out), 32'(e_wdata));
        chk("rd_data", 32'(rd_data), 32'(e_rdata));
      end
    end
  end

  logic [2:0] banks [8];
  int t0, t_adc, t_epc, t_rd, n_ev, n_done;
  int ev_kind [4];
  int ev_t [4];

  initial begin
    banks = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rst_PC_B", 32'(PC_B), 32'd1);
    chk("rst_WE_SE", 32'({WE, SE}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem", 32'({mem_address, mem_sel, mem_data_out}), 32'd0);
    chk("rst_pulses", 32'({adc_done, epc_done, rd_valid, bank_err}), 32'd0);
    step();

    // Single ADC write.
    adc_req = 1'b1; adc_bank = 3'd2; adc_addr = 6'd5; adc_wdata = 16'hA37C;
    step();
    chk("adc_N1_PC_B", 32'(PC_B), 32'd0);
    chk("adc_N1_model_pcb", 32'(x_pcb), 32'd0);
    chk("adc_N1_addr", 32'(mem_address), 32'd5);
    chk("adc_N1_sel", 32'(mem_sel), 32'd2);
    chk("adc_N1_data", 32'(mem_data_out), 32'hA37C);
    step();
    chk("adc_N2_WE", 32'(WE), 32'd1);
    chk("adc_N2_PC_B", 32'(PC_B), 32'd1);
    step();
    chk("adc_N3_done", 32'(adc_done), 32'd1);
    chk("adc_N3_model_done", 32'(x_adc), 32'd1);
    chk("adc_N3_WE", 32'(WE), 32'd0);
    adc_req = 1'b0;
    step();
    step();

    // Single read from bank 1.
    rd_req = 1'b1; rd_bank = 3'd1; rd_addr = 6'd3; mem_read_in = 16'h3000;
    step();
    chk("rd_N1_PC_B", 32'(PC_B), 32'd0);
    step();
    chk("rd_N2_SE", 32'(SE), 32'd1);
    chk("rd_N2_WE", 32'(WE), 32'd0);
    step();
    chk("rd_N3_valid", 32'(rd_valid), 32'd1);
    chk("rd_N3_data", 32'(rd_data), 32'h3000);
    chk("rd_N3_model_data", 32'(e_rdata), 32'h3000);
    rd_req = 1'b0;
    step();
    step();

    // All three at once: ADC, EPC, read, four cycles apart.
    adc_req = 1'b1; adc_bank = 3'd4; adc_addr = 6'd7; adc_wdata = 16'h1234;
    epc_req = 1'b1; epc_addr = 6'd9; epc_wdata = 16'hBEEF;
    rd_req = 1'b1; rd_bank = 3'd2; rd_addr = 6'd10; mem_read_in = 16'h5A5A;
    t0 = cyc; t_adc = -1; t_epc = -1; t_rd = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (adc_done && t_adc < 0) begin t_adc = cyc - t0; adc_req = 1'b0; end
      if (epc_done && t_epc < 0) begin t_epc = cyc - t0; epc_req = 1'b0; end
      if (rd_valid && t_rd < 0) begin t_rd = cyc - t0; rd_req = 1'b0; end
    end
    adc_req = 1'b0; epc_req = 1'b0; rd_req = 1'b0;
    chk("all3_adc_time", 32'(t_adc), 32'd3);
    chk("all3_epc_time", 32'(t_epc), 32'd7);
    chk("all3_rd_time", 32'(t_rd), 32'd11);
    chk("all3_rd_data", 32'(rd_data), 32'h5A5A);
    step();

    // Starvation: ADC held high with a pending read.
    adc_req = 1'b1; adc_bank = 3'd2; adc_addr = 6'd1; adc_wdata = 16'h1111;
    rd_req = 1'b1; rd_bank = 3'd4; rd_addr = 6'd2; mem_read_in = 16'h0F0F;
    t0 = cyc; n_ev = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (n_ev < 4 && adc_done) begin ev_kind[n_ev] = 0; ev_t[n_ev] = cyc - t0; n_ev++; end
      if (n_ev < 4 && rd_valid) begin
        ev_kind[n_ev] = 2; ev_t[n_ev] = cyc - t0; n_ev++; rd_req = 1'b0;
      end
      if (n_ev >= 4) adc_req = 1'b0;
    end
    adc_req = 1'b0; rd_req = 1'b0;
    chk("starve_events", 32'(n_ev), 32'd4);
    if (n_ev == 4) begin
      chk("starve_seq", 32'({ev_kind[0][3:0], ev_kind[1][3:0], ev_kind[2][3:0], ev_kind[3][3:0]}),
          32'h0020);
      chk("starve_t2", 32'(ev_t[2]), 32'd11);
      chk("starve_t3", 32'(ev_t[3]), 32'd15);
    end
    step();

    // Non-one-hot read bank.
    rd_req = 1'b1; rd_bank = 3'b011; rd_addr = 6'd4;
    step();
    chk("berr_N1_pulse", 32'(bank_err), 32'd1);
    chk("berr_N1_model", 32'(x_berr), 32'd1);
    chk("berr_N1_PC_B", 32'(PC_B), 32'd1);
    chk("berr_N1_rd_valid", 32'(rd_valid), 32'd0);
    rd_req = 1'b0;
    step();
    chk("berr_N2_pulse", 32'(bank_err), 32'd0);
    chk("berr_N2_PC_B", 32'(PC_B), 32'd1);
    chk("berr_N2_rd_valid", 32'(rd_valid), 32'd0);
    step();

    // Reset in the middle of ACCESS.
    adc_req = 1'b1; adc_bank = 3'd2; adc_addr = 6'd8; adc_wdata = 16'h7777;
    step();
    step();
    chk("mid_rst_WE_before", 32'(WE), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_WE", 32'(WE), 32'd0);
    chk("mid_rst_SE", 32'(SE), 32'd0);
    chk("mid_rst_PC_B", 32'(PC_B), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    adc_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (adc_done) n_done++;
    end
    chk("mid_rst_no_done", 32'(n_done), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) adc_req = ~adc_req;
      if ($urandom_range(3) == 0) epc_req = ~epc_req;
      if ($urandom_range(3) == 0) rd_req = ~rd_req;
      adc_bank = banks[$urandom_range(7)];
      rd_bank = banks[$urandom_range(7)];
      adc_addr = AW'($urandom);
      epc_addr = AW'($urandom);
      rd_addr = AW'($urandom);
      adc_wdata = DW'($urandom);
      epc_wdata = DW'($urandom);
      mem_read_in = DW'($urandom);
    end
    adc_req = 1'b0; epc_req = 1'b0; rd_req = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
